// File: rtl/disp_timing_pkg.sv
// -----------------------------------------------------------------------------
// disp_timing_pkg
// Shared definitions for the display raster timing generator.
//   disp_state_t    : raster FSM state (IDLE, ACTIVE, VBLANK), 2-bit encoding
//   DISP_W          : default counter width
//   DISP_PIX_MAX    : default last pixel index per line
//   DISP_LINE_MAX   : default last active line index per frame
//   DISP_VB_MAX     : default last vertical-blank line index
// -----------------------------------------------------------------------------
package disp_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_VBLANK = 2'd2
  } disp_state_t;

  localparam int DISP_W        = 4;
  localparam int DISP_PIX_MAX  = 10;
  localparam int DISP_LINE_MAX = 10;
  localparam int DISP_VB_MAX   = 2;

endpackage

// File: rtl/disp_mod_counter.sv
// -----------------------------------------------------------------------------
// disp_mod_counter
// Modulo counter 0..i_max with synchronous clear and a combinational wrap flag.
// Used for the pixel, line and blank-line counters and for the optional pixel
// prescaler of display_timing_gen.
// Ports:
//   clock     in  system clock
//   reset     in  synchronous, active-low reset
//   i_enable  in  advance the count by one (wrapping to 0 after i_max)
//   i_clear   in  force the count to 0 (wins over i_enable)
//   i_max     in  last count value before wrapping
//   o_count   out current count
//   o_wrap    out high while o_count == i_max
// -----------------------------------------------------------------------------
module disp_mod_counter
  import disp_timing_pkg::*;
#(
  parameter int W = DISP_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_enable,
  input  logic         i_clear,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = (r_count == i_max);
  assign o_count = r_count;

  // NOTE: state registers are written with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/display_timing_gen.sv
// -----------------------------------------------------------------------------
// display_timing_gen
// Raster timing generator feeding int_controller. While CSDisplay is high it
// runs frames of (LINE_MAX+1) active lines followed by (VB_MAX+1) blank lines,
// each line being PIX_MAX+1 ticks. Hold freezes the raster.
//
// Optional feature macro: DISP_PIXEL_DIV_EN
//   defined   : a prescaler (0..PIX_DIV-1) divides the clock, one tick per
//               PIX_DIV clocks; parameter PIX_DIV is available.
//   undefined : one tick per clock whenever Hold is low.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   CSDisplay   in   display enable, sampled only at frame boundaries
//   Hold        in   stall; freezes counters, prescaler and state
//   AIPOut      out  pixel index within the current line
//   AILOut      out  active line index (0 during blank)
//   VBOut       out  blank line index (0 during active)
//   FrameStart  out  registered one-clock pulse on the first pixel of a frame
//   LineEnd     out  high while AIPOut==PIX_MAX outside IDLE
//   InBlank     out  high while in VBLANK
// -----------------------------------------------------------------------------
module display_timing_gen
  import disp_timing_pkg::*;
#(
  parameter int W        = DISP_W,
  parameter int PIX_MAX  = DISP_PIX_MAX,
  parameter int LINE_MAX = DISP_LINE_MAX,
  parameter int VB_MAX   = DISP_VB_MAX
`ifdef DISP_PIXEL_DIV_EN
  ,
  parameter int PIX_DIV  = 2
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         CSDisplay,
  input  logic         Hold,
  output logic [W-1:0] AIPOut,
  output logic [W-1:0] AILOut,
  output logic [W-1:0] VBOut,
  output logic         FrameStart,
  output logic         LineEnd,
  output logic         InBlank
);

  disp_state_t r_state;
  logic        r_frame_start;

  logic        w_tick;
  logic        w_running;
  logic        w_idle;
  logic        w_aip_wrap;
  logic        w_ail_wrap;
  logic        w_vb_wrap;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_running = !w_idle;

`ifdef DISP_PIXEL_DIV_EN
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [PW-1:0] w_pre_count;
  logic          w_pre_wrap;

  // The prescaler only runs inside a frame, so every frame starts with a
  // full PIX_DIV-clock first pixel.
  disp_mod_counter #(.W(PW)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .i_enable (!Hold && w_running),
    .i_clear  (w_idle),
    .i_max    (PW'(PIX_DIV - 1)),
    .o_count  (w_pre_count),
    .o_wrap   (w_pre_wrap)
  );

  assign w_tick = !Hold && w_pre_wrap;
`else
  assign w_tick = !Hold;
`endif

  // Pixel counter runs in both ACTIVE and VBLANK; line and blank counters
  // advance only on the last pixel of a line in their own phase. Their
  // natural wrap to 0 gives the AIL=0 / VB=0 values at phase changes.
  disp_mod_counter #(.W(W)) u_pix_cnt (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_tick && w_running),
    .i_clear  (w_idle),
    .i_max    (W'(PIX_MAX)),
    .o_count  (AIPOut),
    .o_wrap   (w_aip_wrap)
  );

  disp_mod_counter #(.W(W)) u_line_cnt (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_tick && (r_state == ST_ACTIVE) && w_aip_wrap),
    .i_clear  (w_idle),
    .i_max    (W'(LINE_MAX)),
    .o_count  (AILOut),
    .o_wrap   (w_ail_wrap)
  );

  disp_mod_counter #(.W(W)) u_vb_cnt (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_tick && (r_state == ST_VBLANK) && w_aip_wrap),
    .i_clear  (w_idle),
    .i_max    (W'(VB_MAX)),
    .o_count  (VBOut),
    .o_wrap   (w_vb_wrap)
  );

  // FrameStart defaults to 0 every clock, so it can never last longer than
  // the single clock following a frame-start transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Hold is deliberately ignored here.
          if (CSDisplay) begin
            r_state       <= ST_ACTIVE;
            r_frame_start <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_tick && w_aip_wrap && w_ail_wrap) begin
            r_state <= ST_VBLANK;
          end
        end
        ST_VBLANK: begin
          // CSDisplay is only looked at on the final blank tick.
          if (w_tick && w_aip_wrap && w_vb_wrap) begin
            if (CSDisplay) begin
              r_state       <= ST_ACTIVE;
              r_frame_start <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign FrameStart = r_frame_start;
  assign LineEnd    = w_running && w_aip_wrap;
  assign InBlank    = (r_state == ST_VBLANK);

endmodule

// File: tb/tb_display_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_display_timing_gen
// Self-checking bench for display_timing_gen at default parameters. A frame
// position model (tick index within a 154-tick frame) predicts every output
// on every clock; directed steps pin the model with literal expectations and
// a randomized phase exercises Hold, CSDisplay and reset at arbitrary times.
// Honours DISP_PIXEL_DIV_EN (PIX_DIV = 2) when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_display_timing_gen;

  localparam int W        = 4;
  localparam int PIX_MAX  = 10;
  localparam int LINE_MAX = 10;
  localparam int VB_MAX   = 2;
  localparam int LINE_LEN = PIX_MAX + 1;
  localparam int ACT_LEN  = (LINE_MAX + 1) * LINE_LEN;
  localparam int FRAME    = ACT_LEN + (VB_MAX + 1) * LINE_LEN;
`ifdef DISP_PIXEL_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         CSDisplay;
  logic         Hold;
  logic [W-1:0] AIPOut;
  logic [W-1:0] AILOut;
  logic [W-1:0] VBOut;
  logic         FrameStart;
  logic         LineEnd;
  logic         InBlank;

  int checks = 0;
  int errors = 0;

  display_timing_gen dut (
    .clock      (clock),
    .reset      (reset),
    .CSDisplay  (CSDisplay),
    .Hold       (Hold),
    .AIPOut     (AIPOut),
    .AILOut     (AILOut),
    .VBOut      (VBOut),
    .FrameStart (FrameStart),
    .LineEnd    (LineEnd),
    .InBlank    (InBlank)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: frame position --------------------
  bit m_started = 0;
  bit m_run     = 0;  // inside a frame (not idle)
  int m_t       = 0;  // tick index within frame, 0..FRAME-1
  bit m_fs      = 0;
  int m_pre     = 0;  // clocks since last tick

  always @(posedge clock) begin : model
    bit n_run;
    int n_t;
    bit n_fs;
    int n_pre;
    n_run = m_run;
    n_t   = m_t;
    n_fs  = 0;
    n_pre = m_pre;
    if (!reset) begin
      n_run = 0; n_t = 0; n_pre = 0;
    end else if (!m_run) begin
      n_pre = 0;
      if (CSDisplay) begin
        n_run = 1; n_t = 0; n_fs = 1;
      end
    end else if (!Hold) begin
      if (m_pre == DIV - 1) begin
        n_pre = 0;
        if (m_t == FRAME - 1) begin
          n_t = 0;
          if (CSDisplay) n_fs = 1;
          else n_run = 0;
        end else begin
          n_t = m_t + 1;
        end
      end else begin
        n_pre = m_pre + 1;
      end
    end
    m_started <= 1;
    m_run     <= n_run;
    m_t       <= n_t;
    m_fs      <= n_fs;
    m_pre     <= n_pre;
  end

  // ---------------- compare process ---------------------------------------
  always @(negedge clock) begin
    int e_aip, e_ail, e_vb, e_blank;
    e_aip = 0; e_ail = 0; e_vb = 0; e_blank = 0;
    if (m_run) begin
      if (m_t < ACT_LEN) begin
        e_aip = m_t % LINE_LEN;
        e_ail = m_t / LINE_LEN;
      end else begin
        e_aip   = (m_t - ACT_LEN) % LINE_LEN;
        e_vb    = (m_t - ACT_LEN) / LINE_LEN;
        e_blank = 1;
      end
    end
    if (m_started) begin
      check("AIPOut",     int'(AIPOut),     e_aip);
      check("AILOut",     int'(AILOut),     e_ail);
      check("VBOut",      int'(VBOut),      e_vb);
      check("FrameStart", int'(FrameStart), int'(m_fs));
      check("LineEnd",    int'(LineEnd),    int'(m_run && e_aip == PIX_MAX));
      check("InBlank",    int'(InBlank),    e_blank);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus with literal pins ----------------------------
  initial begin
    reset = 1'b0; CSDisplay = 1'b1; Hold = 1'b0;
    step(3);
    check("rst_aip",   int'(AIPOut), 0);
    check("rst_fs",    int'(FrameStart), 0);
    check("rst_blank", int'(InBlank), 0);
    check("rst_lend",  int'(LineEnd), 0);

    // Release: first edge enters ACTIVE with FrameStart.
    reset = 1'b1;
    step(1);
    check("rel_fs",  int'(FrameStart), 1);
    check("rel_aip", int'(AIPOut), 0);
    check("rel_ail", int'(AILOut), 0);

    // Full frame.
    step(10 * DIV);
    check("t10_aip",  int'(AIPOut), 10);
    check("t10_lend", int'(LineEnd), 1);
    step(DIV);
    check("t11_ail", int'(AILOut), 1);
    check("t11_aip", int'(AIPOut), 0);
    step(110 * DIV);
    check("t121_blank", int'(InBlank), 1);
    check("t121_vb",    int'(VBOut), 0);
    step(22 * DIV);
    check("t143_vb", int'(VBOut), 2);
    step(11 * DIV);
    check("t154_fs",    int'(FrameStart), 1);
    check("t154_blank", int'(InBlank), 0);

    // Hold at AIPOut = 4 for 5 clocks.
    step(4 * DIV);
    check("pre_hold_aip", int'(AIPOut), 4);
    Hold = 1'b1;
    step(5);
    check("hold_aip",  int'(AIPOut), 4);
    check("hold_lend", int'(LineEnd), 0);
    Hold = 1'b0;
    step(DIV);
    check("post_hold_aip", int'(AIPOut), 5);

    // Drop CSDisplay at AILOut = 3 (tick 33): frame completes, then idle.
    step(28 * DIV);
    check("dis_ail", int'(AILOut), 3);
    CSDisplay = 1'b0;
    step(120 * DIV);
    check("dis_last_vb",  int'(VBOut), 2);
    check("dis_last_aip", int'(AIPOut), 10);
    step(DIV);
    check("dis_idle_blank", int'(InBlank), 0);
    check("dis_idle_fs",    int'(FrameStart), 0);
    step(20);
    check("dis_idle_aip", int'(AIPOut), 0);

    // Reset mid-blank at VBOut = 1, AIPOut = 7 (tick 139).
    CSDisplay = 1'b1;
    step(1);
    check("restart_fs", int'(FrameStart), 1);
    step(139 * DIV);
    check("mb_vb",  int'(VBOut), 1);
    check("mb_aip", int'(AIPOut), 7);
    reset = 1'b0;
    step(1);
    check("mb_rst_aip",   int'(AIPOut), 0);
    check("mb_rst_vb",    int'(VBOut), 0);
    check("mb_rst_blank", int'(InBlank), 0);
    reset = 1'b1;

    // Randomized phase: model compare covers every clock.
    for (int i = 0; i < 4000; i++) begin
      Hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) CSDisplay = ~CSDisplay;
      reset = ($urandom_range(0, 299) != 0);
      step(1);
    end
    reset = 1'b1; Hold = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
